// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default NOP encoding and the IF/ID entry layout
// reused by the decode-side wiring in Cpu.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc_4;
        logic [XLEN-1:0] instruction;
    } if_id_entry_t;

endpackage

// File: rtl/sync_fifo_core.sv
// Generic circular-buffer FIFO: pointers, occupancy count and storage.
// Head entry is read combinationally so a pushed word is visible the next cycle.
module sync_fifo_core #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; count alone defines which slots are live.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_id_pipe_buffer.sv
// Elastic IF/ID buffer: wraps the FIFO core with branch-flush override
// and NOP/zero presentation while empty.
module if_id_pipe_buffer
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [DATA_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_pc_4,
    input  logic [DATA_W-1:0]        in_instruction,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_pc_4,
    output logic [DATA_W-1:0]        out_instruction,
    output logic [$clog2(DEPTH):0]   count
);

    typedef struct packed {
        logic [DATA_W-1:0] pc_4;
        logic [DATA_W-1:0] instruction;
    } entry_t;

    entry_t wr_entry;
    entry_t head_entry;
    logic   fifo_full;
    logic   fifo_empty;
    logic   push;
    logic   pop;

    // Ready/valid depend on stored state only, never on the opposite handshake.
    assign in_ready  = ~fifo_full;
    assign out_valid = ~fifo_empty;

    // A flush cycle shows no transfer on either side.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    assign wr_entry.pc_4        = in_pc_4;
    assign wr_entry.instruction = in_instruction;

    sync_fifo_core #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_core (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .clear_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head_entry),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_pc_4        = fifo_empty ? '0       : head_entry.pc_4;
    assign out_instruction = fifo_empty ? NOP_WORD : head_entry.instruction;

endmodule

// File: tb/tb_if_id_pipe_buffer.sv
// Drives a DEPTH=2 and a DEPTH=4 buffer with the same directed stimulus and
// checks both against queue models every cycle, plus literal spot checks.
module tb_if_id_pipe_buffer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush, in_valid, out_ready;
    logic [31:0] in_pc_4, in_instruction;

    logic        in_ready2, out_valid2, in_ready4, out_valid4;
    logic [31:0] out_pc2, out_ins2, out_pc4, out_ins4;
    logic [1:0]  count2;
    logic [2:0]  count4;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] q2[$];
    logic [63:0] q4[$];

    always #5 clock = ~clock;

    if_id_pipe_buffer #(.DATA_W(32), .DEPTH(2), .NOP_WORD(32'h0)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_pc_4(in_pc_4), .in_instruction(in_instruction),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_pc_4(out_pc2), .out_instruction(out_ins2), .count(count2)
    );

    if_id_pipe_buffer #(.DATA_W(32), .DEPTH(4), .NOP_WORD(32'h0)) u_dut4 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_pc_4(in_pc_4), .in_instruction(in_instruction),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_pc_4(out_pc4), .out_instruction(out_ins4), .count(count4)
    );

    function automatic void chk(string nm, longint unsigned act, longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return 32'hA500_0000 ^ pc;
    endfunction

    // Model: a bounded queue; acceptance is decided on the occupancy before the edge.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q2.delete();
            q4.delete();
        end else if (flush) begin
            q2.delete();
            q4.delete();
        end else begin
            automatic bit acc2 = in_valid && (q2.size() < 2);
            automatic bit acc4 = in_valid && (q4.size() < 4);
            if (out_ready && q2.size() > 0) void'(q2.pop_front());
            if (out_ready && q4.size() > 0) void'(q4.pop_front());
            if (acc2) q2.push_back({in_pc_4, in_instruction});
            if (acc4) q4.push_back({in_pc_4, in_instruction});
        end
    end

    always @(negedge clock) begin
        automatic int s2 = q2.size();
        automatic int s4 = q4.size();
        chk("d2.count",     count2,     s2);
        chk("d2.in_ready",  in_ready2,  s2 < 2);
        chk("d2.out_valid", out_valid2, s2 != 0);
        chk("d2.out_pc_4",  out_pc2,    (s2 != 0) ? q2[0][63:32] : 32'h0);
        chk("d2.out_instr", out_ins2,   (s2 != 0) ? q2[0][31:0]  : 32'h0);
        chk("d4.count",     count4,     s4);
        chk("d4.in_ready",  in_ready4,  s4 < 4);
        chk("d4.out_valid", out_valid4, s4 != 0);
        chk("d4.out_pc_4",  out_pc4,    (s4 != 0) ? q4[0][63:32] : 32'h0);
        chk("d4.out_instr", out_ins4,   (s4 != 0) ? q4[0][31:0]  : 32'h0);
    end

    task automatic drive(input logic f, input logic iv, input logic [31:0] pc, input logic ordy);
        flush          = f;
        in_valid       = iv;
        in_pc_4        = pc;
        in_instruction = ins_of(pc);
        out_ready      = ordy;
        @(posedge clock);
        #1;
        $display("cyc t=%0t flush=%0b iv=%0b pc=0x%0h ordy=%0b -> d2 cnt=%0d head=0x%0h d4 cnt=%0d head=0x%0h",
                 $time, f, iv, pc, ordy, count2, out_pc2, count4, out_pc4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    logic [1:0] wrap_tab [10];

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc_4 = '0; in_instruction = '0;
        wrap_tab = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01};
        repeat (2) @(posedge clock);
        #1;
        chk("rst.count", count2, 0);
        chk("rst.in_ready", in_ready2, 1);
        chk("rst.out_valid", out_valid2, 0);
        chk("rst.out_instr", out_ins2, 32'h0);
        chk("rst.out_pc_4", out_pc2, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Streaming at one per cycle
        drive(0, 1, 32'h4, 1);
        chk("stream.pc0", out_pc2, 32'h4);
        chk("stream.ins0", out_ins2, 32'hA500_0004);
        drive(0, 1, 32'h8, 1);
        chk("stream.pc1", out_pc2, 32'h8);
        chk("stream.cnt1", count2, 1);
        drive(0, 1, 32'hC, 1);
        chk("stream.pc2", out_pc2, 32'hC);
        drive(0, 0, 32'h0, 1);
        chk("stream.drained", out_valid2, 0);

        // Stall and fill
        drive(0, 1, 32'h4, 0);
        drive(0, 1, 32'h8, 0);
        chk("fill.cnt", count2, 2);
        chk("fill.in_ready", in_ready2, 0);
        drive(0, 1, 32'hC, 0);
        chk("fill.hold_pc", out_pc2, 32'h4);
        chk("fill.d4_cnt", count4, 3);
        drive(0, 1, 32'hC, 1);
        chk("fill.pop1", out_pc2, 32'h8);
        chk("fill.cnt_after_pop", count2, 1);
        drive(0, 1, 32'hC, 1);
        chk("fill.late_accept", out_pc2, 32'hC);
        repeat (4) drive(0, 0, 32'h0, 1);
        chk("fill.drained4", count4, 0);

        // Flush while full with push and pop offered
        drive(0, 1, 32'h10, 0);
        drive(0, 1, 32'h14, 0);
        drive(1, 1, 32'h18, 1);
        chk("flush.cnt", count2, 0);
        chk("flush.nop", out_ins2, 32'h0);
        chk("flush.d4_cnt", count4, 0);
        drive(0, 1, 32'h1C, 0);
        chk("flush.repush", out_pc2, 32'h1C);
        chk("flush.repush_cnt", count2, 1);
        drive(0, 0, 32'h0, 1);

        // Wrap-around with mixed stalls
        for (int i = 0; i < 10; i++) begin
            automatic logic [1:0] v = wrap_tab[i];
            drive(0, v[1], 32'h40 + 32'(4 * i), v[0]);
        end
        repeat (5) drive(0, 0, 32'h0, 1);
        chk("wrap.d2_empty", count2, 0);
        chk("wrap.d4_empty", count4, 0);

        // Asynchronous reset mid-stream
        drive(0, 1, 32'h20, 0);
        drive(0, 1, 32'h24, 0);
        chk("areset.pre_cnt", count2, 2);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("areset.cnt", count2, 0);
        chk("areset.valid", out_valid2, 0);
        chk("areset.ready", in_ready2, 1);
        chk("areset.pc", out_pc2, 32'h0);
        chk("areset.ins", out_ins2, 32'h0);
        @(negedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("areset.after", count4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
